uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and framing-error flag.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   rx           in   1  serial line, idle high, asynchronous to clk
//   rx_data_out  out  8  last received byte (LSB first on the line)
//   done_rx      out  1  one-cycle pulse when a frame completes
//   frame_err    out  1  valid with done_rx; 1 = stop bit sampled low
//   rx_active    out  1  high while shifting in data bits (combinational)
module uart_rx #(
    parameter int unsigned clk_freq  = 50000000,
    parameter int unsigned baud_rate = 19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data_out,
    output logic       done_rx,
    output logic       frame_err,
    output logic       rx_active
);

    localparam int unsigned clock_divide = clk_freq / baud_rate;
    localparam int unsigned half_divide  = clock_divide / 2;
    localparam int unsigned CNT_W        = 12;
    localparam int unsigned IDX_W        = 3;

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(clock_divide - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_divide - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sync;
    logic               r_rx_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data_out;
    logic               r_done_rx;
    logic               r_frame_err;

    logic               w_rx_s;
    logic               w_fall;

    // Synchronized line and its falling edge; a line held low never re-triggers.
    assign w_rx_s = r_sync[1];
    assign w_fall = r_rx_d & ~w_rx_s;

    assign rx_data_out = r_rx_data_out;
    assign done_rx     = r_done_rx;
    assign frame_err   = r_frame_err;
    assign rx_active   = (r_state == RX_DATA);

    // Synchronizer, baud timing, bit capture and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RX_IDLE;
            r_sync        <= 2'b11;
            r_rx_d        <= 1'b1;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_rx_data_out <= '0;
            r_done_rx     <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_d    <= w_rx_s;
            r_done_rx <= 1'b0;

            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (w_fall) begin
                        r_state <= RX_START;
                    end
                end

                // Re-check the line at mid start bit to reject glitches.
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= RX_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Byte is published even on a bad stop bit; the flag tells the consumer.
                RX_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt         <= '0;
                        r_rx_data_out <= r_shift;
                        r_frame_err   <= ~w_rx_s;
                        r_done_rx     <= 1'b1;
                        r_state       <= RX_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // A start edge landing here is taken directly so back-to-back frames are not lost.
                RX_DONE: begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= w_fall ? RX_START : RX_IDLE;
                end

                default: begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
